piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 WIDTH, 4, word length in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 data_in  input  WIDTH  parallel word to serialize.
REQ-005 load_valid  input  1  data_in holds a word to send.
REQ-006 load_ready  output  1  block accepts a word this cycle.
REQ-007 serial_out  output  1  serial data bit, MSB first.
REQ-008 serial_valid  output  1  serial_out carries a data bit this cycle.
REQ-009 frame_start  output  1  high during the first (MSB) bit of each word.
REQ-010 frame_done  output  1  high during the last (LSB) bit of each word.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 A transfer SHALL occur at a rising clk edge where load_valid=1, load_ready=1 and reset=0.
REQ-013 load_ready SHALL depend only on registered state, never combinationally on load_valid.
REQ-014 In IDLE: load_ready=1, serial_valid=0, serial_out=0, frame_start=0, frame_done=0.
REQ-015 On a transfer from IDLE: shift register <= data_in, bit counter <= WIDTH-1, state <= SHIFT.
REQ-016 In SHIFT: serial_out = shift register bit [WIDTH-1]; serial_valid=1.
REQ-017 Each SHIFT cycle without a transfer: shift register shifts left one place with 0 fill; counter decrements.
REQ-018 Counter width SHALL be ceil(log2(WIDTH)) bits; it never wraps below 0.
REQ-019 frame_start=1 only in SHIFT with counter=WIDTH-1; frame_done=1 only in SHIFT with counter=0.
REQ-020 In SHIFT, load_ready=1 only when counter=0 (last bit); 0 otherwise.
REQ-021 Last bit with a transfer: reload data_in, counter <= WIDTH-1, stay in SHIFT; the next word's MSB SHALL follow with no idle cycle.
REQ-022 Last bit without a transfer: state <= IDLE.
REQ-023 Latency: for a word accepted at edge N, the MSB SHALL be on serial_out in the cycle after edge N; bit k (0 = MSB) appears in cycle N+1+k; each word occupies exactly WIDTH cycles.
REQ-024 load_valid while load_ready=0 SHALL have no effect; data_in is ignored except on a transfer.
REQ-025 Bit order SHALL match the downstream left-shifting SIPO stage, so that after WIDTH valid bits the SIPO holds the original data_in.
REQ-026 serial_out, serial_valid, frame_start and frame_done SHALL be derived from registers only; no input-to-output combinational path is allowed.

Reset
REQ-027 With reset=1 at an edge: state <= IDLE, shift register <= 0, counter <= 0; reset overrides any simultaneous transfer.
REQ-028 While reset=1, load_ready SHALL be 0; after the first edge with reset=0, load_ready=1.
REQ-029 Reset mid-word SHALL abort the word: no further serial_valid for it, frame_done not asserted, and the partial word is discarded.
REQ-030 Output values after reset: serial_out=0, serial_valid=0, frame_start=0, frame_done=0.

Verification
REQ-031 WIDTH=4, single load of 4'b1011 -> serial_out 1,0,1,1 on 4 consecutive cycles with serial_valid=1; frame_start on bit 1, frame_done on bit 4; load_ready=0 on bits 1-3, 1 on bit 4 and afterwards.
REQ-032 Back-to-back: 4'hA then 4'h5 with load_valid held -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; frame_start on bits 1 and 5; then IDLE.
REQ-033 load_valid=1 with data 4'h0 during bits 1-3 of 4'hF -> ignored; stream stays 1,1,1,1.
REQ-034 Reset asserted during bit 2 of 4'hF -> next cycle serial_valid=0, serial_out=0, no frame_done; load_ready=0 while in reset, 1 after release.
REQ-035 Loopback into a 4-bit SIPO model clocked only on serial_valid cycles, 200 random words with random load_valid gaps -> SIPO output equals each word on the cycle after its frame_done.
REQ-036 WIDTH=8, load 8'h81 -> serial_out 1,0,0,0,0,0,0,1; frame_done on bit 8.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load-side handshake and serial-side outputs of the PISO serializer.
// The slave modport is the serializer; the master modport is whatever feeds it words.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_done;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output frame_done
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB first, with back-to-back word reload on the last bit.
// All serial-side outputs are decoded from registered state only.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  piso_serializer_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic in_shift;
  logic last_bit;
  logic load_ready;
  logic transfer;

  assign in_shift = (state_q == StShift);
  assign last_bit = in_shift && (cnt_q == '0);
  // Gating with reset keeps ready low during reset without looking at load_valid.
  assign load_ready = !reset && ((state_q == StIdle) || last_bit);
  assign transfer   = bus.load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          shift_d = bus.data_in;
          cnt_d   = CntMax;
          state_d = StShift;
        end
      end
      StShift: begin
        if (transfer) begin
          shift_d = bus.data_in;
          cnt_d   = CntMax;
        end else begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.serial_valid = in_shift;
  assign bus.serial_out   = in_shift && shift_q[WIDTH-1];
  assign bus.frame_start  = in_shift && (cnt_q == CntMax);
  assign bus.frame_done   = last_bit;

endmodule
